// File: rtl/gen_clk_div_if.sv
// Bus between the clock-divider block and its consumer: enable/resync
// controls toward the divider, divided clocks, lock flag and optional
// rising-edge strobes back. Strobe signal exists only with GEN_CLK_STB_EN.
interface gen_clk_div_if #(
  parameter int NUM_DIV = 3
) ();
  logic               enb;
  logic               sync;
  logic [NUM_DIV-1:0] clk_div;
  logic               locked;
`ifdef GEN_CLK_STB_EN
  logic [NUM_DIV-1:0] stb;
`endif

  modport master (
    output enb, sync,
`ifdef GEN_CLK_STB_EN
    input  stb,
`endif
    input  clk_div, locked
  );

  modport slave (
    input  enb, sync,
`ifdef GEN_CLK_STB_EN
    output stb,
`endif
    output clk_div, locked
  );
endinterface

// File: rtl/gen_clk_div.sv
// gen_clk_div: NUM_DIV binary-divided clocks (/2 .. /2^NUM_DIV) of clk_8f
// taken from one free-running counter, with a lock flag that rises once every
// output has completed a full aligned period, and a resync input.
// Optional rising-edge strobes are built when GEN_CLK_STB_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | out of reset, no enabled edge seen yet
// ST_WARMUP | counting, outputs not yet through a full aligned period
// ST_LOCKED | counter has wrapped once since reset/sync; locked high
module gen_clk_div #(
  parameter int NUM_DIV = 3
) (
  input  logic         clk_8f,
  input  logic         rst,
  gen_clk_div_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WARMUP = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t             state_q;
  logic [NUM_DIV-1:0] cnt_q;
  logic [NUM_DIV-1:0] cnt_d;
  logic [NUM_DIV-1:0] clk_div_q;
  logic               locked_q;
`ifdef GEN_CLK_STB_EN
  logic [NUM_DIV-1:0] stb_q;
`endif

  // Next counter value; wraps naturally modulo 2^NUM_DIV.
  always_comb begin
    cnt_d = cnt_q + NUM_DIV'(1);
  end

  // Counter, divided clocks, lock FSM and strobes; priority rst > sync > enb.
  always_ff @(posedge clk_8f) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_div_q <= '0;
      locked_q  <= 1'b0;
      state_q   <= ST_IDLE;
`ifdef GEN_CLK_STB_EN
      stb_q     <= '0;
`endif
    end else if (bus.sync) begin
      cnt_q     <= '0;
      clk_div_q <= '0;
      locked_q  <= 1'b0;
      state_q   <= ST_WARMUP;
`ifdef GEN_CLK_STB_EN
      stb_q     <= '0;
`endif
    end else if (bus.enb) begin
      cnt_q     <= cnt_d;
      clk_div_q <= cnt_d;
`ifdef GEN_CLK_STB_EN
      // A bit rising 0->1 in the counter is a rising edge of that output.
      stb_q     <= cnt_d & ~cnt_q;
`endif
      case (state_q)
        ST_IDLE: begin
          state_q  <= ST_WARMUP;
          locked_q <= 1'b0;
        end
        ST_WARMUP: begin
          // The wrap edge is where every output falls together.
          if (cnt_d == '0) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          locked_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end else begin
      // Frozen: counter, outputs and state hold so divided clocks stretch.
`ifdef GEN_CLK_STB_EN
      stb_q <= '0;
`endif
    end
  end

  assign bus.clk_div = clk_div_q;
  assign bus.locked  = locked_q;
`ifdef GEN_CLK_STB_EN
  assign bus.stb     = stb_q;
`endif

endmodule

// File: doc/gen_clk_div.md
Name: gen_clk_div

Overview:
- Parametrised successor to the two-output clock generator.
- Derives NUM_DIV binary-divided clocks (÷2, ÷4, … ÷2^NUM_DIV) from clk_8f using a single counter.
- Adds a lock indicator and a resynchronisation input, which the original lacks.
- Feeds the serializer/deserializer and byte-striping stages that run at clk_4f/clk_2f/clk_f.

Parameters:
- NUM_DIV, 3, number of divided outputs; legal range 1..8; clk_div[i] = clk_8f / 2^(i+1).

Ports:
- clk_8f  input  1  fastest clock; all logic on its posedge.
- rst  input  1  reset.
- enb  input  1  count enable; low freezes the block.
- sync  input  1  resynchronise pulse; restarts the counter and clears lock.
- clk_div  output  NUM_DIV  divided clocks; bit 0 = ÷2, bit NUM_DIV-1 = ÷2^NUM_DIV.
- locked  output  1  high once all outputs have completed a full aligned period.
- stb  output  NUM_DIV  rising-edge strobes; present only with GEN_CLK_STB_EN.

Interface decision: reset rst, synchronous, active-high; clock clk_8f.

Behaviour:
- Single NUM_DIV-bit counter cnt.
- Priority on each posedge clk_8f: rst > sync > enb.
- rst=1:
  - cnt=0, clk_div=0, locked=0, stb=0, state=IDLE.
  - Applies mid-operation with no residual state.
- sync=1 (rst=0):
  - cnt=0, clk_div=0, stb=0, locked=0, state=WARMUP.
  - Takes effect regardless of enb.
- enb=1 (no rst/sync):
  - nxt=cnt+1, wrapping modulo 2^NUM_DIV.
  - cnt<=nxt; clk_div[i]<=nxt[i] (registered, zero added latency beyond one edge).
- enb=0:
  - cnt, clk_div, state and locked hold; stb forced 0.
  - Divided clocks stretch and do not glitch.
- Output properties:
  - clk_div[i] has a 50% duty cycle with period 2^(i+1) clk_8f cycles.
  - All outputs fall together on the edge where cnt wraps 2^NUM_DIV-1 -> 0.
  - The first enabled edge after reset drives clk_div[0] high.
- FSM states IDLE, WARMUP, LOCKED:
  - IDLE -> WARMUP on the first edge with enb=1.
  - WARMUP -> LOCKED on the enabled edge where cnt wraps to 0; locked<=1 on that same edge.
  - LOCKED stays LOCKED through enb=0 and counter wraps; leaves only on sync (-> WARMUP) or rst (-> IDLE).
  - Unreachable encodings recover to IDLE.
- Lock timing: locked first rises on the 2^NUM_DIV-th enabled edge after reset or sync.
- NUM_DIV=1: only a ÷2 output; locked rises on the 2nd enabled edge.
- Outputs are registers, never combinational from inputs.

Optional Feature:
- Macro: GEN_CLK_STB_EN.
- Defined:
  - Port stb[NUM_DIV-1:0] exists.
  - stb[i] is registered high for exactly one clk_8f cycle on the edge where clk_div[i] goes 0->1, i.e. nxt[i]=1 and cnt[i]=0 with enb=1.
  - stb is 0 during reset, sync and enb=0.
- Not defined:
  - Port stb is absent; no strobe logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset then count (NUM_DIV=3): rst 2 cycles, then enb=1 for 8 edges -> clk_div[2] = 0,0,0,1,1,1,1,0; clk_div[0] = 1,0,1,0,1,0,1,0; locked=0 on edges 1-7, 1 on edge 8.
- Enable freeze: after 5 enabled edges (cnt=5, clk_div=3'b101), enb=0 for 4 cycles -> clk_div stays 3'b101 and locked unchanged; re-enable -> next value 3'b110.
- Resync while locked: locked=1 at cnt=3, pulse sync 1 cycle -> clk_div=3'b000, locked=0; locked returns high 8 enabled edges later.
- Priority: rst=1 with sync=1 and enb=1 -> state IDLE, all outputs 0; sync=1 with enb=0 -> counter cleared anyway.
- Reset mid-operation: rst asserted at cnt=6 while locked -> next edge clk_div=0, locked=0; lock requires a fresh 8 enabled edges.
- With GEN_CLK_STB_EN, 16 enabled edges -> stb[0] pulses on edges 1,3,5,…; stb[1] on edges 2,6,10,14; stb[2] on edges 4,12; each pulse exactly one cycle wide.
